// File: rtl/clk_monoflop.sv
`default_nettype none
// ============================================================================
//  Module   : clk_monoflop
//  Purpose  : Synchronous, non-retriggerable monoflop. A rising edge on
//             'trigger', qualified by 'enable', starts a registered high
//             pulse on 'q' lasting PULSE_CYCLES clock periods.
//  Ports    : clk     - system clock, rising edge
//             rst_n   - synchronous active-low reset
//             trigger - level input, rising edge requests a pulse
//             enable  - start qualifier, sampled on the detection cycle only
//             q       - registered pulse output
//  Revision : 1.0 - initial release
// ============================================================================
module clk_monoflop #(
  parameter int PULSE_CYCLES = 1,   // 1..65535
  parameter int CNT_W        = 16   // must hold PULSE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  input  logic enable,
  output logic q
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             trig_hist_q;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_w;
  logic             start_w;

  // Edge detect against the previous trigger sample.
  assign rise_w  = trigger & ~trig_hist_q;
  // Edges while the pulse is active (including its final cycle) are ignored.
  assign start_w = rise_w & enable & ~pulse_q;

  always_comb begin
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    if (pulse_q) begin
      if (cnt_q != CNT_ZERO) begin
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        pulse_d = 1'b0;
      end
    end else if (start_w) begin
      pulse_d = 1'b1;
      cnt_d   = CNT_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // History forced high: a trigger already high at reset release must
      // first be seen low before it can fire.
      trig_hist_q <= 1'b1;
      pulse_q     <= 1'b0;
      cnt_q       <= CNT_ZERO;
    end else begin
      trig_hist_q <= trigger;
      pulse_q     <= pulse_d;
      cnt_q       <= cnt_d;
    end
  end

  assign q = pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_monoflop.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_monoflop
//  Purpose  : Directed self-checking bench for clk_monoflop with one instance
//             at PULSE_CYCLES=1 and one at PULSE_CYCLES=4.
//  Ports    : none (top-level bench)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_monoflop;

  logic clk = 1'b0;
  logic rst_n;
  logic trg1, en1, trg4, en4;
  logic q1, q4;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  clk_monoflop #(.PULSE_CYCLES(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .trigger(trg1), .enable(en1), .q(q1)
  );

  clk_monoflop #(.PULSE_CYCLES(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .trigger(trg4), .enable(en4), .q(q4)
  );

  task automatic chk(input logic obs, input logic exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the PULSE_CYCLES=1 instance, clock once, check q1.
  task automatic s1(input logic t, input logic e, input logic exp, input string tag);
    trg1 = t; en1 = e;
    tick();
    chk(q1, exp, tag);
  endtask

  // Drive the PULSE_CYCLES=4 instance, clock once, check q4.
  task automatic s4(input logic t, input logic e, input logic exp, input string tag);
    trg4 = t; en4 = e;
    tick();
    chk(q4, exp, tag);
  endtask

  initial begin
    rst_n = 1'b0; trg1 = 1'b0; en1 = 1'b0; trg4 = 1'b0; en4 = 1'b0;
    #2;
    tick(); tick();
    chk(q1, 1'b0, "reset_q1");
    chk(q4, 1'b0, "reset_q4");
    rst_n = 1'b1;

    // Idle with enable, then held trigger gives one single-cycle pulse.
    for (int i = 0; i < 10; i++) s1(1'b0, 1'b1, 1'b0, "idle");
    s1(1'b1, 1'b1, 1'b1, "held_first");
    for (int i = 0; i < 9; i++) s1(1'b1, 1'b1, 1'b0, "held_rest");

    // High 10, low 1, high 1: two pulses.
    s1(1'b0, 1'b1, 1'b0, "p2_low0");
    s1(1'b1, 1'b1, 1'b1, "p2_rise1");
    for (int i = 0; i < 9; i++) s1(1'b1, 1'b1, 1'b0, "p2_hold");
    s1(1'b0, 1'b1, 1'b0, "p2_gap");
    s1(1'b1, 1'b1, 1'b1, "p2_rise2");
    s1(1'b0, 1'b1, 1'b0, "p2_end");

    // Same pattern with enable low: nothing fires.
    s1(1'b1, 1'b0, 1'b0, "dis_rise1");
    for (int i = 0; i < 9; i++) s1(1'b1, 1'b0, 1'b0, "dis_hold");
    s1(1'b0, 1'b0, 1'b0, "dis_gap");
    s1(1'b1, 1'b0, 1'b0, "dis_rise2");
    s1(1'b0, 1'b0, 1'b0, "dis_end");

    // Enable and trigger rise together, enable drops next cycle.
    s1(1'b1, 1'b1, 1'b1, "sim_fire");
    s1(1'b1, 1'b0, 1'b0, "sim_after");
    // Enable raised while trigger still high: no pulse.
    s1(1'b1, 1'b1, 1'b0, "late_en");
    s1(1'b1, 1'b1, 1'b0, "late_en2");

    // Rising edge every 2nd cycle with PULSE_CYCLES=1.
    s1(1'b0, 1'b1, 1'b0, "alt_low");
    for (int i = 0; i < 3; i++) begin
      s1(1'b1, 1'b1, 1'b1, "alt_hi");
      s1(1'b0, 1'b1, 1'b0, "alt_lo");
    end

    // PULSE_CYCLES=4: second edge mid-pulse ignored.
    s4(1'b0, 1'b1, 1'b0, "p4_idle");
    s4(1'b1, 1'b1, 1'b1, "p4_e0");
    s4(1'b0, 1'b1, 1'b1, "p4_e1");
    s4(1'b1, 1'b1, 1'b1, "p4_e2_reedge");
    s4(1'b0, 1'b1, 1'b1, "p4_e3");
    s4(1'b0, 1'b1, 1'b0, "p4_e4_end");
    // Edge 5 cycles after start: new 4-cycle pulse.
    s4(1'b1, 1'b1, 1'b1, "p4_f0");
    s4(1'b0, 1'b1, 1'b1, "p4_f1");
    s4(1'b0, 1'b1, 1'b1, "p4_f2");
    s4(1'b0, 1'b1, 1'b1, "p4_f3");
    // Edge on the exact end cycle is ignored, and held high does not refire.
    s4(1'b1, 1'b1, 1'b0, "p4_f4_endedge");
    s4(1'b1, 1'b1, 1'b0, "p4_f5_held");
    s4(1'b0, 1'b1, 1'b0, "p4_f6_low");

    // Trigger held through reset release: no pulse.
    trg4 = 1'b1; en4 = 1'b1; rst_n = 1'b0;
    tick();
    chk(q4, 1'b0, "rst_hold_in");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) s4(1'b1, 1'b1, 1'b0, "rst_hold_rel");

    // Reset mid-pulse drops q at that edge.
    s4(1'b0, 1'b1, 1'b0, "mid_low");
    s4(1'b1, 1'b1, 1'b1, "mid_start");
    s4(1'b1, 1'b1, 1'b1, "mid_run");
    rst_n = 1'b0;
    tick();
    chk(q4, 1'b0, "mid_reset");
    rst_n = 1'b1;
    s4(1'b1, 1'b1, 1'b0, "mid_rel");
    s4(1'b1, 1'b1, 1'b0, "mid_rel2");
    // Fresh edge after reset works with a full pulse.
    s4(1'b0, 1'b1, 1'b0, "post_low");
    s4(1'b1, 1'b1, 1'b1, "post_g0");
    s4(1'b0, 1'b1, 1'b1, "post_g1");
    s4(1'b0, 1'b1, 1'b1, "post_g2");
    s4(1'b0, 1'b1, 1'b1, "post_g3");
    s4(1'b0, 1'b1, 1'b0, "post_g4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
